// File: rtl/fifo_burst_pkg.sv
// Shared types for the FIFO burst reader: FSM state and the buffered stream word.
package fifo_burst_pkg;

    localparam int PKG_DWIDTH = 32;

    typedef logic [PKG_DWIDTH-1:0] data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    typedef struct packed {
        data_t data;
        logic  sop;
        logic  eop;
    } burst_word_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus output stream of the burst reader, bundled as one interface.
interface fifo_burst_reader_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
);
    logic [DWIDTH-1:0] fifo_q_i;
    logic              fifo_empty_i;
    logic              fifo_full_i;
    logic [AWIDTH-1:0] fifo_usedw_i;
    logic              fifo_rdreq_o;
    logic [DWIDTH-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              sop_o;
    logic              eop_o;

    modport master (
        input  fifo_q_i, fifo_empty_i, fifo_full_i, fifo_usedw_i, ready_i,
        output fifo_rdreq_o, data_o, valid_o, sop_o, eop_o
    );

    modport slave (
        output fifo_q_i, fifo_empty_i, fifo_full_i, fifo_usedw_i, ready_i,
        input  fifo_rdreq_o, data_o, valid_o, sop_o, eop_o
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready buffer: output register plus one skid register.
// skid_full is registered so the upstream pop never depends on ready combinationally.
module fifo_skid_buf
    import fifo_burst_pkg::*;
#(
    parameter type T = burst_word_t
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic push,
    input  T     din,
    output logic skid_full,
    output T     dout,
    output logic valid,
    input  logic ready
);
    T     skid_q;
    logic adv;

    assign adv = !valid || ready;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            dout      <= '0;
            valid     <= 1'b0;
            skid_q    <= '0;
            skid_full <= 1'b0;
        end else if (adv) begin
            if (skid_full) begin
                // older skid word goes out first; a concurrent push refills the skid
                dout      <= skid_q;
                valid     <= 1'b1;
                skid_q    <= din;
                skid_full <= push;
            end else begin
                if (push) dout <= din;
                valid <= push;
            end
        end else if (push) begin
            skid_q    <= din;
            skid_full <= 1'b1;
        end
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// Waits for a full burst in a show-ahead FIFO, pops BURST_LEN words and streams them
// with sop/eop. Define FIFO_BURST_TIMEOUT_EN to flush short bursts after TIMEOUT idle cycles.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input logic                 clk_i,
    input logic                 arst_i,
    fifo_burst_reader_if.master bus
);
    localparam int            CW   = AWIDTH + 1;
    localparam logic [CW-1:0] BLEN = CW'(BURST_LEN);

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              sop;
        logic              eop;
    } word_t;

    burst_state_t  state_q, state_d;
    logic [CW-1:0] fill, len_q, len_d, rd_cnt, rd_cnt_d;
    logic          rdreq, skid_full, last;
    word_t         push_word, out_word;

    // full flag disambiguates a completely full FIFO whose usedw has wrapped to 0
    assign fill = {bus.fifo_full_i, bus.fifo_usedw_i};
    assign last = (rd_cnt == len_q - CW'(1));

`ifdef FIFO_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    logic          partial, timed_out;

    assign partial   = (state_q == IDLE) && (fill != '0) && (fill < BLEN);
    assign timed_out = partial && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)                     idle_cnt <= '0;
        else if (partial && !timed_out) idle_cnt <= idle_cnt + TW'(1);
        else                            idle_cnt <= '0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt;
        rdreq    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill >= BLEN) begin
                    state_d  = BURST;
                    len_d    = BLEN;
                    rd_cnt_d = '0;
                end
`ifdef FIFO_BURST_TIMEOUT_EN
                else if (timed_out) begin
                    state_d  = BURST;
                    len_d    = fill;
                    rd_cnt_d = '0;
                end
`endif
            end
            BURST: begin
                rdreq = !bus.fifo_empty_i && !skid_full;
                if (rdreq) begin
                    rd_cnt_d = rd_cnt + CW'(1);
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            len_q   <= BLEN;
            rd_cnt  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rd_cnt  <= rd_cnt_d;
        end
    end

    always_comb begin
        push_word      = '0;
        push_word.data = bus.fifo_q_i;
        push_word.sop  = (rd_cnt == '0);
        push_word.eop  = last;
    end

    fifo_skid_buf #(.T(word_t)) u_skid (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .push      (rdreq),
        .din       (push_word),
        .skid_full (skid_full),
        .dout      (out_word),
        .valid     (bus.valid_o),
        .ready     (bus.ready_i)
    );

    assign bus.fifo_rdreq_o = rdreq;
    assign bus.data_o       = out_word.data;
    assign bus.sop_o        = out_word.sop;
    assign bus.eop_o        = out_word.eop;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based show-ahead FIFO, stream logger, scenario tasks.
module tb_fifo_burst_reader;
    localparam int DW = 32, AW = 4, BL = 16, TO = 64, DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DWIDTH(DW), .AWIDTH(AW)) ifc ();

    fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk_i  (clk),
        .arst_i (rst),
        .bus    (ifc)
    );

    int tests = 0, fails = 0;

    // show-ahead FIFO model
    logic [DW-1:0] fq[$];
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    int            uflow   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) fq.delete();
        else begin
            if (ifc.fifo_rdreq_o) begin
                if (fq.size() == 0) uflow++;
                else void'(fq.pop_front());
            end
            if (wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
        end
        ifc.fifo_q_i     <= (fq.size() > 0) ? fq[0] : '0;
        ifc.fifo_empty_i <= (fq.size() == 0);
        ifc.fifo_full_i  <= (fq.size() == DEPTH);
        ifc.fifo_usedw_i <= AW'(fq.size());
    end

    // stream logger: accepted words, pop edges, stall stability, buffer occupancy
    int              cyc = 0, occ = 0, stall_err = 0, occ_err = 0;
    logic [DW+1:0]   got[$];
    int              got_cyc[$];
    int              pop_edge[$];
    logic            stall_q = 1'b0;
    logic [DW+1:0]   stall_w = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            occ     = 0;
            stall_q = 1'b0;
        end else begin
            cyc++;
            if (stall_q && ({ifc.valid_o, ifc.data_o, ifc.sop_o, ifc.eop_o} !== {1'b1, stall_w}))
                stall_err++;
            if (ifc.fifo_rdreq_o) begin
                pop_edge.push_back(cyc);
                occ++;
            end
            if (ifc.valid_o && ifc.ready_i) begin
                got.push_back({ifc.data_o, ifc.sop_o, ifc.eop_o});
                got_cyc.push_back(cyc);
                occ--;
            end
            if (occ > 2 || occ < 0) occ_err++;
            stall_q = ifc.valid_o && !ifc.ready_i;
            stall_w = {ifc.data_o, ifc.sop_o, ifc.eop_o};
        end
    end

    logic [DW-1:0] wdata[$];

    task automatic feed(input int from, output int e0, output int e1);
        int k;
        k  = from;
        e0 = 0;
        e1 = 0;
        for (int n = 0; n < 4000 && k < wdata.size(); n++) begin
            @(negedge clk);
            if (fq.size() < DEPTH) begin
                wr_en   = 1'b1;
                wr_data = wdata[k];
                if (k == from) e0 = cyc + 1;
                e1 = cyc + 1;
                k++;
            end else wr_en = 1'b0;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_got(input int target, input int bound);
        for (int i = 0; i < bound && got.size() < target; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        ifc.ready_i = 1'b0;
        wr_en = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if ({ifc.valid_o, ifc.sop_o, ifc.eop_o, ifc.fifo_rdreq_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got valid/sop/eop/rdreq=%b want 0000",
                     {ifc.valid_o, ifc.sop_o, ifc.eop_o, ifc.fifo_rdreq_o});
        end
        tests++;
        if (ifc.data_o !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", ifc.data_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({ifc.valid_o, ifc.fifo_rdreq_o} !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle: got valid/rdreq=%b want 00", {ifc.valid_o, ifc.fifo_rdreq_o});
        end
    endtask

    task automatic test_single_burst();
        int g0, p0, e0, e1;
        logic [DW+1:0] e;
        ifc.ready_i = 1'b1;
        g0 = got.size();
        p0 = pop_edge.size();
        wdata.delete();
        for (int i = 0; i < BL; i++) wdata.push_back(DW'(i));
        feed(0, e0, e1);
        wait_got(g0 + BL, 200);
        repeat (4) @(negedge clk);
        tests++;
        if (got.size() != g0 + BL) begin
            fails++;
            $display("FAIL single_count: got %0d words want %0d", got.size() - g0, BL);
        end else begin
            tests++;
            if (pop_edge[p0] != e1 + 2) begin
                fails++;
                $display("FAIL single_start: first pop at edge %0d want %0d", pop_edge[p0], e1 + 2);
            end
            tests++;
            if (got_cyc[g0] != pop_edge[p0] + 1) begin
                fails++;
                $display("FAIL single_latency: accepted at %0d want %0d", got_cyc[g0], pop_edge[p0] + 1);
            end
            tests++;
            if (got_cyc[g0+BL-1] - got_cyc[g0] != BL - 1) begin
                fails++;
                $display("FAIL single_rate: span %0d want %0d", got_cyc[g0+BL-1] - got_cyc[g0], BL - 1);
            end
            for (int i = 0; i < BL; i++) begin
                e = {DW'(i), (i == 0), (i == BL - 1)};
                tests++;
                if (got[g0+i] !== e) begin
                    fails++;
                    $display("FAIL single_word[%0d]: got %h want %h", i, got[g0+i], e);
                end
            end
        end
        tests++;
        if (ifc.fifo_empty_i !== 1'b1 || pop_edge.size() - p0 != BL) begin
            fails++;
            $display("FAIL single_drain: empty=%b pops=%0d want 1/%0d",
                     ifc.fifo_empty_i, pop_edge.size() - p0, BL);
        end
    endtask

`ifdef FIFO_BURST_TIMEOUT_EN
    task automatic test_timeout();
        int g0, p0, e0, e1;
        logic [DW+1:0] e;
        ifc.ready_i = 1'b1;
        g0 = got.size();
        p0 = pop_edge.size();
        wdata.delete();
        for (int i = 0; i < 5; i++) wdata.push_back($urandom);
        feed(0, e0, e1);
        wait_got(g0 + 5, TO + 100);
        repeat (20) @(negedge clk);
        tests++;
        if (got.size() != g0 + 5 || pop_edge.size() != p0 + 5) begin
            fails++;
            $display("FAIL timeout_count: got %0d words %0d pops want 5", got.size() - g0, pop_edge.size() - p0);
        end else begin
            tests++;
            if (pop_edge[p0] < e0 + TO || pop_edge[p0] > e0 + TO + 3) begin
                fails++;
                $display("FAIL timeout_when: first pop at %0d want %0d..%0d", pop_edge[p0], e0 + TO, e0 + TO + 3);
            end
            for (int i = 0; i < 5; i++) begin
                e = {wdata[i], (i == 0), (i == 4)};
                tests++;
                if (got[g0+i] !== e) begin
                    fails++;
                    $display("FAIL timeout_word[%0d]: got %h want %h", i, got[g0+i], e);
                end
            end
        end
    endtask
`else
    task automatic test_below_threshold();
        int g0, p0, e0, e1;
        logic [DW+1:0] e;
        ifc.ready_i = 1'b1;
        g0 = got.size();
        p0 = pop_edge.size();
        wdata.delete();
        for (int i = 0; i < BL; i++) wdata.push_back($urandom);
        wdata.pop_back();
        feed(0, e0, e1);
        repeat (1000) @(negedge clk);
        tests++;
        if (pop_edge.size() != p0 || got.size() != g0) begin
            fails++;
            $display("FAIL below_hold: pops=%0d words=%0d want 0/0", pop_edge.size() - p0, got.size() - g0);
        end
        wdata.push_back($urandom);
        feed(BL - 1, e0, e1);
        wait_got(g0 + BL, 200);
        tests++;
        if (got.size() != g0 + BL) begin
            fails++;
            $display("FAIL below_count: got %0d words want %0d", got.size() - g0, BL);
        end else begin
            for (int i = 0; i < BL; i++) begin
                e = {wdata[i], (i == 0), (i == BL - 1)};
                tests++;
                if (got[g0+i] !== e) begin
                    fails++;
                    $display("FAIL below_word[%0d]: got %h want %h", i, got[g0+i], e);
                end
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        int g0, s0, o0, u0, e0, e1;
        logic [DW+1:0] e;
        g0 = got.size();
        s0 = stall_err;
        o0 = occ_err;
        u0 = uflow;
        wdata.delete();
        for (int i = 0; i < 64; i++) wdata.push_back($urandom);
        fork
            feed(0, e0, e1);
            begin
                for (int n = 0; n < 3000 && got.size() < g0 + 64; n++) begin
                    @(negedge clk);
                    ifc.ready_i = 1'($urandom_range(0, 1));
                end
                ifc.ready_i = 1'b1;
            end
        join
        wait_got(g0 + 64, 100);
        tests++;
        if (got.size() != g0 + 64) begin
            fails++;
            $display("FAIL bp_count: got %0d words want 64", got.size() - g0);
        end else begin
            for (int i = 0; i < 64; i++) begin
                e = {wdata[i], (i % BL == 0), (i % BL == BL - 1)};
                tests++;
                if (got[g0+i] !== e) begin
                    fails++;
                    $display("FAIL bp_word[%0d]: got %h want %h", i, got[g0+i], e);
                end
            end
        end
        tests++;
        if (stall_err != s0) begin
            fails++;
            $display("FAIL bp_stable: %0d stalled cycles changed output, want 0", stall_err - s0);
        end
        tests++;
        if (occ_err != o0 || uflow != u0) begin
            fails++;
            $display("FAIL bp_occupancy: overfill=%0d underflow=%0d want 0/0", occ_err - o0, uflow - u0);
        end
    endtask

    task automatic test_full_fifo();
        int g0, p0, e0, e1;
        logic [DW+1:0] e;
        ifc.ready_i = 1'b0;
        g0 = got.size();
        p0 = pop_edge.size();
        wdata.delete();
        for (int i = 0; i < BL; i++) wdata.push_back($urandom);
        feed(0, e0, e1);
        repeat (20) @(negedge clk);
        tests++;
        if (pop_edge.size() - p0 != 2) begin
            fails++;
            $display("FAIL full_stall_pops: got %0d pops want 2", pop_edge.size() - p0);
        end
        tests++;
        if ({ifc.valid_o, ifc.data_o, ifc.sop_o, ifc.eop_o} !== {1'b1, wdata[0], 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL full_head: got v=%b d=%h s=%b e=%b want 1 %h 1 0",
                     ifc.valid_o, ifc.data_o, ifc.sop_o, ifc.eop_o, wdata[0]);
        end
        ifc.ready_i = 1'b1;
        wait_got(g0 + BL, 200);
        tests++;
        if (got.size() != g0 + BL) begin
            fails++;
            $display("FAIL full_count: got %0d words want %0d", got.size() - g0, BL);
        end else begin
            for (int i = 0; i < BL; i++) begin
                e = {wdata[i], (i == 0), (i == BL - 1)};
                tests++;
                if (got[g0+i] !== e) begin
                    fails++;
                    $display("FAIL full_word[%0d]: got %h want %h", i, got[g0+i], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int g0, p0, e0, e1;
        logic [DW+1:0] e;
        ifc.ready_i = 1'b1;
        g0 = got.size();
        p0 = pop_edge.size();
        wdata.delete();
        for (int i = 0; i < 3 * BL; i++) wdata.push_back($urandom);
        feed(0, e0, e1);
        wait_got(g0 + 3 * BL, 300);
        tests++;
        if (got.size() != g0 + 3 * BL || pop_edge.size() < p0 + 3 * BL) begin
            fails++;
            $display("FAIL b2b_count: got %0d words want %0d", got.size() - g0, 3 * BL);
        end else begin
            for (int b = 0; b < 3; b++) begin
                tests++;
                if (pop_edge[p0+BL*b+BL-1] - pop_edge[p0+BL*b] != BL - 1) begin
                    fails++;
                    $display("FAIL b2b_rate[%0d]: span %0d want %0d", b,
                             pop_edge[p0+BL*b+BL-1] - pop_edge[p0+BL*b], BL - 1);
                end
                if (b > 0) begin
                    tests++;
                    if (pop_edge[p0+BL*b] - pop_edge[p0+BL*b-1] < 2) begin
                        fails++;
                        $display("FAIL b2b_gap[%0d]: gap %0d want >=2", b,
                                 pop_edge[p0+BL*b] - pop_edge[p0+BL*b-1]);
                    end
                end
            end
            for (int i = 0; i < 3 * BL; i++) begin
                e = {wdata[i], (i % BL == 0), (i % BL == BL - 1)};
                tests++;
                if (got[g0+i] !== e) begin
                    fails++;
                    $display("FAIL b2b_word[%0d]: got %h want %h", i, got[g0+i], e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int g0, p0, e0, e1;
        logic [DW+1:0] e;
        ifc.ready_i = 1'b1;
        p0 = pop_edge.size();
        wdata.delete();
        for (int i = 0; i < BL; i++) wdata.push_back($urandom);
        feed(0, e0, e1);
        for (int n = 0; n < 100 && pop_edge.size() - p0 < 7; n++) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({ifc.valid_o, ifc.sop_o, ifc.eop_o, ifc.fifo_rdreq_o, ifc.data_o} !== '0) begin
            fails++;
            $display("FAIL midrst_zero: got v/s/e/rd=%b data=%h want 0", {ifc.valid_o, ifc.sop_o,
                     ifc.eop_o, ifc.fifo_rdreq_o}, ifc.data_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        g0 = got.size();
        p0 = pop_edge.size();
        repeat (50) @(negedge clk);
        tests++;
        if (got.size() != g0 || pop_edge.size() != p0 || ifc.valid_o !== 1'b0) begin
            fails++;
            $display("FAIL midrst_quiet: words=%0d pops=%0d valid=%b want 0/0/0",
                     got.size() - g0, pop_edge.size() - p0, ifc.valid_o);
        end
        wdata.delete();
        for (int i = 0; i < BL; i++) wdata.push_back($urandom);
        feed(0, e0, e1);
        wait_got(g0 + BL, 200);
        tests++;
        if (got.size() != g0 + BL) begin
            fails++;
            $display("FAIL midrst_count: got %0d words want %0d", got.size() - g0, BL);
        end else begin
            for (int i = 0; i < BL; i++) begin
                e = {wdata[i], (i == 0), (i == BL - 1)};
                tests++;
                if (got[g0+i] !== e) begin
                    fails++;
                    $display("FAIL midrst_word[%0d]: got %h want %h", i, got[g0+i], e);
                end
            end
        end
        tests++;
        if (uflow != 0) begin
            fails++;
            $display("FAIL underflow: %0d pops while empty, want 0", uflow);
        end
    endtask

    initial begin
        ifc.ready_i = 1'b0;
        #2;
        test_reset();
        test_single_burst();
`ifdef FIFO_BURST_TIMEOUT_EN
        test_timeout();
`else
        test_below_threshold();
`endif
        test_backpressure();
        test_full_fifo();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side stage placed directly downstream of the single-clock show-ahead `fifo`. It waits until the FIFO holds a full burst, pops exactly `BURST_LEN` words and presents them as a valid/ready stream with start/end-of-packet markers. A two-entry skid buffer keeps `fifo_rdreq_o` independent of the downstream `ready_i`.

## Interface
- `DWIDTH`, 32: data word width; must match the FIFO `DWIDTH`.
- `AWIDTH`, 8: FIFO `usedw` width; FIFO depth is 2**`AWIDTH`.
- `BURST_LEN`, 16: words per burst; legal range 1 .. 2**`AWIDTH`.
- `TIMEOUT`, 64: idle cycles before a short burst is flushed; used only with `FIFO_BURST_TIMEOUT_EN`; legal range ≥ 1.
- `clk_i  in  1`: the single clock.
- `arst_i  in  1`: reset, asynchronous and active-high.
- `fifo_q_i  in  DWIDTH`: FIFO show-ahead head word; valid whenever `fifo_empty_i` = 0.
- `fifo_empty_i  in  1`: FIFO empty flag.
- `fifo_full_i  in  1`: FIFO full flag.
- `fifo_usedw_i  in  AWIDTH`: FIFO fill level.
- `fifo_rdreq_o  out  1`: pop request to the FIFO. The pop takes effect at the rising edge.
- `data_o  out  DWIDTH`: stream data.
- `valid_o  out  1`: stream valid.
- `ready_i  in  1`: stream ready from downstream.
- `sop_o  out  1`: marks the first word of a burst.
- `eop_o  out  1`: marks the last word of a burst.

## Operation
- **Fill level:**
  - `fill` = {`fifo_full_i`, `fifo_usedw_i`}, `AWIDTH`+1 bits.
  - When full, this covers the case where `usedw` has wrapped to 0.
- **State machine:** two states, IDLE and BURST.
- **IDLE:**
  - Go to BURST when `fill` ≥ `BURST_LEN`.
  - On entry: `len_q` ← `BURST_LEN`, `rd_cnt` ← 0.
  - `fifo_rdreq_o` = 0.
- **BURST:**
  - `fifo_rdreq_o` = `!fifo_empty_i && !skid_full`.
  - Each pop pushes {`fifo_q_i`, `sop` = (`rd_cnt` == 0), `eop` = (`rd_cnt` == `len_q` − 1)} into the skid buffer and increments `rd_cnt`.
  - Return to IDLE on the pop with `eop` = 1.
  - IDLE does not wait for the output to drain, so bursts run back-to-back.
- **Skid buffer:**
  - Output register plus one skid register.
  - `skid_full` = skid register occupied.
  - Output advances when `!valid_o || ready_i`.
  - No word is ever dropped or duplicated.
  - `valid_o` stays high, with `data_o`, `sop_o` and `eop_o` held stable, until `ready_i` is high.
- **Underflow:** `fifo_rdreq_o` is never asserted while `fifo_empty_i` = 1.
- **Simultaneous events:** a pop and an output handshake in the same cycle are both honoured. Buffer occupancy is unchanged.
- **Reset mid-burst:** the burst is abandoned and buffered words are discarded. The FIFO is expected to be reset together with this block.

## Timing
- **Reset values:**
  - `valid_o` = 0, `sop_o` = 0, `eop_o` = 0, `data_o` = 0.
  - `fifo_rdreq_o` = 0.
  - State IDLE, `rd_cnt` = 0, skid register empty.
- **Burst start:** `fill` reaching `BURST_LEN` in cycle N gives `fifo_rdreq_o` high in cycle N+1.
- **Latency:** a word popped at edge E appears on `data_o` with `valid_o` = 1 in the cycle after E.
- **Throughput:** with `ready_i` held at 1, one word per cycle within a burst.
- **Back-to-back bursts:** the next burst's first pop is no earlier than 2 cycles after the previous `eop` pop. This lets `fifo_usedw_i` settle.
- **Backpressure:**
  - `ready_i` = 0 stops pops within 2 cycles, once the output register and the skid register are both occupied.
  - `fifo_rdreq_o` has no combinational path from `ready_i`.

## Configuration
- **Macro:** `FIFO_BURST_TIMEOUT_EN`.
- **Defined:**
  - An idle counter runs while the block is in IDLE with 0 < `fill` < `BURST_LEN`. It clears on any other condition.
  - When it reaches `TIMEOUT`, enter BURST with `len_q` ← `fill`: a short burst with correct `sop` and `eop`.
- **Undefined:** no idle counter. Words below `BURST_LEN` wait indefinitely.

## Structure
- **Package `fifo_burst_pkg`:**
  - State enum `burst_state_t` (IDLE, BURST).
  - Struct `burst_word_t` {data, sop, eop}, parameterised through a `DWIDTH`-sized typedef.
- **Sub-module `fifo_skid_buf`:** 2-entry valid/ready skid buffer of `burst_word_t`.
- **Top:** the state machine, counters and timeout.

## Test plan
- **Single burst:** `BURST_LEN`=16; write 16 words 0..15, `ready_i`=1 → 16 consecutive outputs 0..15; `sop` on 0, `eop` on 15; FIFO empty afterwards.
- **Below threshold:** write 15 words, macro undefined → `fifo_rdreq_o` stays 0 for 1000 cycles. Write a 16th word → burst 0..15.
- **Backpressure:** `ready_i` toggles 1,0,0,1 randomly over 64 words → output order exact, no loss, `data_o` stable while stalled, at most 2 buffered words.
- **Full FIFO:** `AWIDTH`=4, `BURST_LEN`=16; fill 16 words so `usedw`=0 and `full`=1 → burst starts and completes correctly.
- **Timeout:** macro defined, `TIMEOUT`=64; write 5 words and idle → after 64 cycles a 5-word burst with `sop` on word 0 and `eop` on word 4.
- **Reset mid-burst:** `arst_i` asserted after 7 of 16 words popped → all outputs 0 immediately. After release with an empty FIFO, no output until 16 new words are written.
